// File: rtl/led_activity_driver.sv
// led_activity_driver
//   Per-port link/activity LED controller. Each channel shows:
//     off      - link down
//     steady   - link up, no recent traffic
//     blinking - traffic seen within the last HOLD_TICKS blink rising edges
//   A global mode input can override all channels with all-off, all-on or a
//   walking lamp test. Channel state machines keep running in every mode, so
//   returning to normal mode shows live status on the very next edge.
//
// Ports
//   clk       in   1         system clock, all logic on posedge
//   reset     in   1         synchronous active-high reset
//   blink     in   1         slow square wave (level) from the blink generator
//   mode      in   2         00 normal, 01 all off, 10 all on, 11 lamp test
//   link_up   in   NUM_LEDS  per-port link status (level)
//   activity  in   NUM_LEDS  per-port traffic event (pulse, any width)
//   led       out  NUM_LEDS  registered LED drive, 1 = lit

module led_activity_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int HOLD_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                blink,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] link_up,
  input  logic [NUM_LEDS-1:0] activity,
  output logic [NUM_LEDS-1:0] led
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [HW-1:0]       HOLD_LOAD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]       HOLD_ZERO = HW'(0);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(NUM_LEDS - 1);
  localparam logic [IW-1:0]       IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0]       IDX_ONE   = IW'(1);
  localparam logic [NUM_LEDS-1:0] LAMP_BASE = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACT  = 2'd2
  } ch_state_t;

  logic                blink_q_r;
  logic                tick_s;
  ch_state_t           state_r [NUM_LEDS];
  ch_state_t           state_n [NUM_LEDS];
  logic [HW-1:0]       hold_r  [NUM_LEDS];
  logic [HW-1:0]       hold_n  [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_act_r;
  logic [NUM_LEDS-1:0] led_act_n;
  logic [NUM_LEDS-1:0] ch_val_s;
  logic [IW-1:0]       lamp_idx_r;
  logic [IW-1:0]       lamp_idx_n;
  logic [NUM_LEDS-1:0] led_r;
  logic [NUM_LEDS-1:0] led_n;

  // One-cycle strobe on each rising edge of the blink square wave.
  assign tick_s = blink & ~blink_q_r;

  // Per-channel next state: link loss dominates, then activity, then tick.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      state_n[i]   = state_r[i];
      hold_n[i]    = hold_r[i];
      led_act_n[i] = led_act_r[i];
      if (!link_up[i]) begin
        state_n[i]   = ST_DOWN;
        hold_n[i]    = HOLD_ZERO;
        led_act_n[i] = 1'b0;
      end else begin
        case (state_r[i])
          ST_DOWN: begin
            // Activity arriving with the link-up edge is intentionally ignored.
            state_n[i]   = ST_IDLE;
            hold_n[i]    = HOLD_ZERO;
            led_act_n[i] = 1'b0;
          end
          ST_IDLE: begin
            if (activity[i]) begin
              state_n[i]   = ST_ACT;
              hold_n[i]    = HOLD_LOAD;
              led_act_n[i] = 1'b0;
            end else begin
              state_n[i]   = ST_IDLE;
            end
          end
          ST_ACT: begin
            if (activity[i]) begin
              // Reload wins over a coincident tick; phase is left untouched.
              hold_n[i] = HOLD_LOAD;
            end else if (tick_s) begin
              if (hold_r[i] == HOLD_ONE) begin
                state_n[i] = ST_IDLE;
                hold_n[i]  = HOLD_ZERO;
              end else if (hold_r[i] > HOLD_ONE) begin
                hold_n[i]    = hold_r[i] - HOLD_ONE;
                led_act_n[i] = ~led_act_r[i];
              end else begin
                // hold==0 is unreachable in ACT; never underflow.
                hold_n[i] = hold_r[i];
              end
            end else begin
              hold_n[i] = hold_r[i];
            end
          end
          default: begin
            state_n[i]   = ST_DOWN;
            hold_n[i]    = HOLD_ZERO;
            led_act_n[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // Channel LED value derived from the current channel state.
  always_comb begin
    ch_val_s = {NUM_LEDS{1'b0}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (state_r[i])
        ST_DOWN: ch_val_s[i] = 1'b0;
        ST_IDLE: ch_val_s[i] = 1'b1;
        ST_ACT:  ch_val_s[i] = led_act_r[i];
        default: ch_val_s[i] = 1'b0;
      endcase
    end
  end

  // Lamp-test position: parked at 0 outside lamp test, walks on ticks inside it.
  always_comb begin
    lamp_idx_n = lamp_idx_r;
    if (mode != 2'b11) begin
      lamp_idx_n = IDX_ZERO;
    end else if (tick_s) begin
      if (lamp_idx_r == IDX_LAST) begin
        lamp_idx_n = IDX_ZERO;
      end else begin
        lamp_idx_n = lamp_idx_r + IDX_ONE;
      end
    end else begin
      lamp_idx_n = lamp_idx_r;
    end
  end

  // Output mux feeding the LED register.
  always_comb begin
    led_n = {NUM_LEDS{1'b0}};
    case (mode)
      2'b00:   led_n = ch_val_s;
      2'b01:   led_n = {NUM_LEDS{1'b0}};
      2'b10:   led_n = {NUM_LEDS{1'b1}};
      2'b11:   led_n = LAMP_BASE << lamp_idx_r;
      default: led_n = {NUM_LEDS{1'b0}};
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q_r  <= 1'b0;
      led_act_r  <= {NUM_LEDS{1'b0}};
      lamp_idx_r <= IDX_ZERO;
      led_r      <= {NUM_LEDS{1'b0}};
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_r[i] <= ST_DOWN;
        hold_r[i]  <= HOLD_ZERO;
      end
    end else begin
      blink_q_r  <= blink;
      led_act_r  <= led_act_n;
      lamp_idx_r <= lamp_idx_n;
      led_r      <= led_n;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_r[i] <= state_n[i];
        hold_r[i]  <= hold_n[i];
      end
    end
  end

  assign led = led_r;

endmodule
